// File: rtl/bcd2binary_seq_pkg.sv
// rtl/bcd2binary_seq_pkg.sv - shared state encoding and BCD constants
package bcd2binary_seq_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CONV = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam logic [3:0] BCD_MAX_DIGIT = 4'd9;

endpackage

// File: rtl/bcd2binary_seq_if.sv
// rtl/bcd2binary_seq_if.sv - start/busy/done conversion handshake bundle
interface bcd2binary_seq_if #(
  parameter int N = 16
);
  logic         start;
  logic [N-1:0] text;
  logic [N-1:0] number;
  logic         busy;
  logic         done;
  logic         error;

  modport master (
    output start,
    output text,
    input  number,
    input  busy,
    input  done,
    input  error
  );

  modport slave (
    input  start,
    input  text,
    output number,
    output busy,
    output done,
    output error
  );
endinterface

// File: rtl/bcd2binary_seq_bcd_digit_mac.sv
// rtl/bcd2binary_seq_bcd_digit_mac.sv - combinational acc*10 + digit with bad-digit flag
module bcd_digit_mac
  import bcd2binary_seq_pkg::*;
#(
  parameter int N = 16
) (
  input  logic [N-1:0] acc,
  input  logic [3:0]   digit,
  output logic [N-1:0] acc_next,
  output logic         digit_bad
);
  // times ten as shift-add, wrapping modulo 2^N
  assign acc_next  = (acc << 3) + (acc << 1) + {{(N-4){1'b0}}, digit};
  assign digit_bad = (digit > BCD_MAX_DIGIT);
endmodule

// File: rtl/bcd2binary_seq.sv
// rtl/bcd2binary_seq.sv - multi-cycle BCD to binary converter, one digit per clock
module bcd2binary_seq
  import bcd2binary_seq_pkg::*;
#(
  parameter int N = 16,
  parameter int W = 4
) (
  input logic             clk,
  input logic             btnU,
  bcd2binary_seq_if.slave bus
);
  localparam int            CW       = (W > 1) ? $clog2(W) : 1;
  localparam logic [CW-1:0] LAST_CNT = CW'(W - 1);

  state_t        state, state_next;
  logic [N-1:0]  acc, sr, acc_next;
  logic [CW-1:0] cnt;
  logic          bad, bad_next, digit_bad;
  logic          load, step, finish;
  logic [N-1:0]  number_q;
  logic          error_q, done_q, busy_q;

  bcd_digit_mac #(.N(N)) u_mac (
    .acc       (acc),
    .digit     (sr[N-1:N-4]),
    .acc_next  (acc_next),
    .digit_bad (digit_bad)
  );

  assign bad_next = bad | digit_bad;

  // state register
  always_ff @(posedge clk or posedge btnU) begin
    if (btnU) state <= IDLE;
    else      state <= state_next;
  end

  // next state and datapath strobes; the unused encoding falls back to IDLE
  always_comb begin
    state_next = state;
    load       = 1'b0;
    step       = 1'b0;
    finish     = 1'b0;
    case (state)
      IDLE: begin
        if (bus.start) begin
          load       = 1'b1;
          state_next = CONV;
        end
      end
      CONV: begin
        step = 1'b1;
        if (cnt == LAST_CNT) begin
          finish     = 1'b1;
          state_next = DONE;
        end
      end
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // accumulator, MSD-first shift register, digit counter and bad-digit latch
  always_ff @(posedge clk or posedge btnU) begin
    if (btnU) begin
      acc <= '0;
      sr  <= '0;
      cnt <= '0;
      bad <= 1'b0;
    end else if (load) begin
      acc <= '0;
      sr  <= bus.text;
      cnt <= '0;
      bad <= 1'b0;
    end else if (step) begin
      acc <= acc_next;
      sr  <= {sr[N-5:0], 4'h0};
      cnt <= cnt + 1'b1;
      bad <= bad_next;
    end
  end

  // registered outputs; result taken straight from the final digit's next-value logic
  always_ff @(posedge clk or posedge btnU) begin
    if (btnU) begin
      number_q <= '0;
      error_q  <= 1'b0;
      done_q   <= 1'b0;
      busy_q   <= 1'b0;
    end else begin
      if (finish) begin
        number_q <= bad_next ? '0 : acc_next;
        error_q  <= bad_next;
      end
      done_q <= (state_next == DONE);
      busy_q <= (state_next != IDLE);
    end
  end

  assign bus.number = number_q;
  assign bus.error  = error_q;
  assign bus.done   = done_q;
  assign bus.busy   = busy_q;
endmodule

// File: tb/tb_bcd2binary_seq.sv
// tb/tb_bcd2binary_seq.sv - randomized and directed self-checking bench for bcd2binary_seq
module tb_bcd2binary_seq;
  localparam int N = 16;
  localparam int W = 4;

  logic clk;
  logic btnU;
  int   n_checks;
  int   n_errors;

  bcd2binary_seq_if #(.N(N)) bus ();

  bcd2binary_seq #(.N(N), .W(W)) dut (
    .clk  (clk),
    .btnU (btnU),
    .bus  (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%0h expected=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // reference: decimal digit accumulation, error forces zero
  function automatic logic [16:0] ref_conv(input logic [15:0] t);
    int v;
    bit bad;
    v   = 0;
    bad = 0;
    for (int i = W - 1; i >= 0; i--) begin
      int d;
      d = (int'(t) >> (4 * i)) & 15;
      if (d > 9) bad = 1;
      v = v * 10 + d;
    end
    if (bad) v = 0;
    return {bad, 16'(v % 65536)};
  endfunction

  function automatic logic [15:0] to_bcd(input int v);
    return {4'(v / 1000), 4'((v / 100) % 10), 4'((v / 10) % 10), 4'(v % 10)};
  endfunction

  // mode 0 plain, 1 restart attempt with 5555 during CONV, 2 text changed mid-conversion
  task automatic convert(input logic [15:0] t, input int mode);
    logic [16:0] exp;
    int cyc;
    int extra_done;
    exp = ref_conv(t);
    bus.text  = t;
    bus.start = 1'b1;
    @(posedge clk); #1;
    bus.start = 1'b0;
    check("busy_at_start", 32'(bus.busy), 32'd1);
    if (mode != 0) begin
      bus.text = 16'h5555;
      if (mode == 1) bus.start = 1'b1;
    end
    cyc = 0;
    while (!bus.done && cyc < 20) begin
      @(posedge clk); #1;
      cyc++;
      bus.start = 1'b0;
    end
    check("latency", 32'(cyc), 32'(W));
    check("number", 32'(bus.number), 32'(exp[15:0]));
    check("error", 32'(bus.error), 32'(exp[16]));
    check("busy_in_done", 32'(bus.busy), 32'd1);
    extra_done = 0;
    for (int i = 0; i < 4; i++) begin
      @(posedge clk); #1;
      if (bus.done) extra_done++;
    end
    check("single_done", 32'(extra_done), 32'd0);
    check("idle_after", 32'(bus.busy), 32'd0);
    check("number_held", 32'(bus.number), 32'(exp[15:0]));
  endtask

  initial begin
    int last_done;
    int cyc;
    int v;
    int guard;
    logic [15:0] t;
    n_checks  = 0;
    n_errors  = 0;
    btnU      = 1'b1;
    bus.start = 1'b0;
    bus.text  = '0;
    #1;
    check("rst_number", 32'(bus.number), 32'd0);
    check("rst_error", 32'(bus.error), 32'd0);
    check("rst_done", 32'(bus.done), 32'd0);
    check("rst_busy", 32'(bus.busy), 32'd0);
    @(posedge clk); @(posedge clk); #1;
    btnU = 1'b0;
    @(posedge clk); #1;

    convert(16'h1234, 0);
    convert(16'h9999, 0);
    convert(16'h0000, 0);
    convert(16'h0007, 0);
    convert(16'h12A4, 0);
    convert(16'h0042, 0);
    convert(16'h0815, 1);
    convert(16'h3141, 2);

    // asynchronous reset between edges mid-conversion
    bus.text  = 16'h4321;
    bus.start = 1'b1;
    @(posedge clk); #1;
    bus.start = 1'b0;
    @(posedge clk); #3;
    btnU = 1'b1;
    #1;
    check("midrst_number", 32'(bus.number), 32'd0);
    check("midrst_error", 32'(bus.error), 32'd0);
    check("midrst_busy", 32'(bus.busy), 32'd0);
    check("midrst_done", 32'(bus.done), 32'd0);
    @(posedge clk); #1;
    btnU = 1'b0;
    cyc  = 0;
    for (int i = 0; i < 8; i++) begin
      @(posedge clk); #1;
      if (bus.done || bus.busy) cyc++;
    end
    check("midrst_quiet", 32'(cyc), 32'd0);
    convert(16'h0042, 0);

    // random words, digits 0..15 so bad digits appear
    for (int i = 0; i < 40; i++) begin
      t = 16'($urandom);
      if ($urandom_range(0, 1) == 1) t = to_bcd(int'($urandom_range(0, 9999)));
      convert(t, int'($urandom_range(0, 2)));
    end

    // round trip 0..9999 with start held high
    v         = 0;
    last_done = -1;
    cyc       = 0;
    guard     = 0;
    bus.text  = to_bcd(0);
    bus.start = 1'b1;
    while (v < 10000 && guard < 80000) begin
      @(posedge clk); #1;
      cyc++;
      guard++;
      if (bus.done) begin
        check("rt_number", 32'(bus.number), 32'(v));
        check("rt_error", 32'(bus.error), 32'd0);
        if (last_done >= 0) check("rt_spacing", 32'(cyc - last_done), 32'(W + 2));
        last_done = cyc;
        v++;
        bus.text = to_bcd(v % 10000);
      end
    end
    check("rt_complete", 32'(v), 32'd10000);
    bus.start = 1'b0;
    repeat (10) @(posedge clk);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end
endmodule

// File: doc/bcd2binary_seq.md
Name: bcd2binary_seq

Overview:
Multi-cycle BCD-to-binary converter: the inverse of the binary-to-BCD converters on the board display path. It accepts a W-digit packed BCD word (MSD in the top nibble), processes one digit per clock as acc = acc*10 + digit, and reports the binary value with a start/busy/done handshake. Sits between keypad or switch BCD entry and the binary counter/arithmetic logic. Also used to round-trip check the binary-to-BCD converters.

Parameters:
N, 16, width of the BCD input word and of the binary output.
W, 4, number of BCD digits converted; N must equal 4*W.

Ports:
clk  input  1  system clock, rising edge.
btnU  input  1  reset, asynchronous, active-high.
start  input  1  request a conversion; sampled only in IDLE.
text  input  N  packed BCD; digit i occupies bits [4i+3:4i], digit W-1 is the MSD.
number  output  N  binary result; registered; held until the next done.
busy  output  1  high in CONV and DONE.
done  output  1  one-cycle pulse; number and error are valid from this cycle on.
error  output  1  registered with number; 1 if any input digit > 9.

Behaviour:
- Reset (btnU high, asynchronous): state=IDLE; number=0, error=0, done=0, busy=0; accumulator, shift register, digit counter and error latch = 0. Reset mid-conversion aborts it with no done pulse.
- States:
  - IDLE: if start=1 at a clock edge, load shift register <= text, acc <= 0, cnt <= 0, bad <= 0, go to CONV. Otherwise stay.
  - CONV: each edge does the following:
    - acc <= acc*10 + sr[N-1:N-4], computed as (acc<<3)+(acc<<1)+digit, truncated to N bits.
    - sr <= sr<<4.
    - bad <= bad | (digit > 9).
    - cnt <= cnt+1.
    - On the edge that processes digit 0 (cnt == W-1), load number and error directly from the next-value logic, then go to DONE.
  - DONE: done=1 and busy=1 for exactly one cycle, then go to IDLE unconditionally.
- Latency: start sampled at edge k; number/error update at edge k+W; done is high during the cycle between edges k+W and k+W+1. With start held high, a new conversion begins every W+2 edges.
- Error rule: if any digit > 9, error=1 and number=0 (forced, not the partial accumulate). Otherwise error=0.
- start while busy is ignored. text may change after the start edge without effect, because it is captured at that edge.
- Arithmetic: for W=4, N=16 the maximum is 9999 (0x270F), so no overflow. For other parameters the result is modulo 2^N with no flag.
- Outputs done, busy, number and error are all registered; there is no combinational path from inputs to outputs.
- Counter width is clog2(W) bits, minimum 1.

Decomposition:
- Shared package/header:
  - State encodings: IDLE=2'd0, CONV=2'd1, DONE=2'd2 (2'd3 is illegal and recovers to IDLE).
  - Constant BCD_MAX_DIGIT=4'd9.
- One sub-module: bcd_digit_mac. Combinational; inputs acc[N-1:0] and digit[3:0]; outputs acc*10+digit and a digit_bad flag. Instantiated once inside bcd2binary_seq.

Test Plan:
- Reset then text=16'h1234, start pulse at edge k → busy from k; at edge k+W number=16'h04D2 (1234), error=0; done is high for exactly one cycle; idle afterwards.
- text=16'h9999 → number=16'h270F. text=16'h0000 → number=0, done still pulses. text=16'h0007 → number=7.
- text=16'h12A4 → error=1, number=0. A following conversion of 16'h0042 → error=0, number=16'h002A.
- Two ignored-input checks:
  - start re-pulsed during CONV with text=16'h5555 → ignored; the result is still from the original text, and exactly one done pulse occurs.
  - text changed mid-conversion → ignored.
- btnU asserted mid-CONV (between clock edges) → all outputs 0 immediately, no done pulse. A fresh start after release converts correctly.
- Round-trip, exhaustive 0..9999:
  - Drive each binary value through the binary-to-BCD converter into text, with start held high.
  - Check that number equals the original value and error=0 on every done.
  - Check that done spacing is W+2 cycles.
